// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multi-cycle load/store processor. One instruction runs
// through FETCH -> DECODE -> {EXEC -> [MEM] -> [WB] | BRANCH | JUMP | TRAP}.
// The datapath control outputs are decoded from the state register and the
// opcode field of the external instruction register. Only ir_write and
// pc_write also look at an input: mem_ready in FETCH and cond_true in BRANCH.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   opcode       IR[31:26], stable from DECODE until the instruction retires
//   cond_true    branch condition from the ALU
//   mem_ready    memory handshake, honoured only in FETCH and MEM
//   mem_req      memory access request
//   iord         address select (0 = PC, 1 = ALU result)
//   mem_read     read size  (00 none, 01 word, 10 half, 11 byte)
//   mem_write    write size (00 none, 01 byte, 10 half, 11 word)
//   ir_write     IR load strobe
//   pc_write     PC load strobe
//   pc_src       PC source (00 PC+4, 01 branch, 10 jump, 11 rs)
//   reg_write    register file write strobe
//   reg_dst      destination (00 rt, 01 rd, 10 $31)
//   mem_to_reg   write-back source (00 ALU, 01 MDR, 10 PC link)
//   alu_src_b    ALU B operand (00 reg, 01 imm, 10 constant 4)
//   alu_op       ALU operation
//   illegal      sticky trap flag, cleared only by reset
//   state        current state code
//   instr_count  retired-instruction counter (wraps at 16 bits)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        cond_true,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        iord,
    output logic [1:0]  mem_read,
    output logic [1:0]  mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_src_b,
    output logic [5:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    localparam logic [5:0] OP_LH  = 6'b001110;
    localparam logic [5:0] OP_LW  = 6'b001111;
    localparam logic [5:0] OP_LB  = 6'b010100;
    localparam logic [5:0] OP_SB  = 6'b010000;
    localparam logic [5:0] OP_SH  = 6'b010001;
    localparam logic [5:0] OP_SW  = 6'b010010;
    localparam logic [5:0] OP_J   = 6'b010101;
    localparam logic [5:0] OP_JR  = 6'b010110;
    localparam logic [5:0] OP_JAL = 6'b010111;
    localparam logic [5:0] ALU_ADD  = 6'b000110;
    localparam logic [5:0] ALU_FUNC = 6'b111111;

    state_t      state_reg;
    logic        illegal_reg;
    logic [15:0] count_reg;

    // Opcode class decode
    logic is_r, is_imm, is_br, is_load, is_store, is_jmp;

    always_comb begin
        is_r     = 1'b0;
        is_imm   = 1'b0;
        is_br    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jmp   = 1'b0;
        case (opcode)
            6'b000000:                                   is_r     = 1'b1;
            6'b000110, 6'b000111, 6'b001000,
            6'b001001, 6'b001101, 6'b010011:             is_imm   = 1'b1;
            6'b001010, 6'b001011, 6'b001100:             is_br    = 1'b1;
            OP_LH, OP_LW, OP_LB:                         is_load  = 1'b1;
            OP_SB, OP_SH, OP_SW:                         is_store = 1'b1;
            OP_J, OP_JR, OP_JAL:                         is_jmp   = 1'b1;
            default: ;
        endcase
    end

    // State, trap flag and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_RESET;
            illegal_reg <= 1'b0;
            count_reg   <= 16'h0000;
        end else begin
            case (state_reg)
                S_RESET:  state_reg <= S_FETCH;
                S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    if (is_br)
                        state_reg <= S_BRANCH;
                    else if (is_jmp)
                        state_reg <= S_JUMP;
                    else if (is_r || is_imm || is_load || is_store)
                        state_reg <= S_EXEC;
                    else begin
                        state_reg   <= S_TRAP;
                        illegal_reg <= 1'b1;
                    end
                end
                S_EXEC:   state_reg <= (is_load || is_store) ? S_MEM : S_WB;
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_load)
                            state_reg <= S_WB;
                        else begin
                            // A store retires on its accepted memory cycle
                            state_reg <= S_FETCH;
                            count_reg <= count_reg + 16'd1;
                        end
                    end
                end
                S_WB, S_BRANCH, S_JUMP: begin
                    state_reg <= S_FETCH;
                    count_reg <= count_reg + 16'd1;
                end
                S_TRAP:   state_reg <= S_TRAP;
                default:  state_reg <= S_RESET;
            endcase
        end
    end

    // Control decode from the state register and opcode
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_read   = 2'b00;
        mem_write  = 2'b00;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 6'b000000;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
                // IR and PC load only on the accepting cycle
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_op    = ALU_FUNC;
                    alu_src_b = 2'b00;
                end else begin
                    alu_op    = opcode;
                    alu_src_b = 2'b01;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                case (opcode)
                    OP_LW:   mem_read  = 2'b01;
                    OP_LH:   mem_read  = 2'b10;
                    OP_LB:   mem_read  = 2'b11;
                    OP_SB:   mem_write = 2'b01;
                    OP_SH:   mem_write = 2'b10;
                    OP_SW:   mem_write = 2'b11;
                    default: ;
                endcase
            end
            S_WB: begin
                if (is_r) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end else if (is_imm) begin
                    reg_write = 1'b1;
                end else if (is_load) begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
            end
            S_BRANCH: begin
                alu_op    = opcode;
                alu_src_b = 2'b00;
                pc_src    = 2'b01;
                pc_write  = cond_true;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = (opcode == OP_JR) ? 2'b11 : 2'b10;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign illegal     = illegal_reg;
    assign state       = state_reg;
    assign instr_count = count_reg;

endmodule
